probe_capture_core: RTL and testbench
=====================================

// Module: probe_capture_core
// PURPOSE
//  Parametrised on-chip capture buffer for motor-control debug probes (duty, rotateState, HIN_x, SPI lines, counters).
//  Samples PROBE_W signals every controlCLK cycle into a DEPTH-entry circular RAM, with mask/value trigger and programmable pre-trigger.
//  Captured window is read back through a registered read port by the host-side readout logic.
//  Sits beside the drive logic, on the same clock domain as the signals it observes.
// PARAMETERS
//  PROBE_W  16   probe vector width, 1..64
//  DEPTH    256  sample entries; power of two, 16..4096
//  ADDR_W   $clog2(DEPTH)  derived; not to be overridden
// PORTS
//  controlCLK  in   1        sample and logic clock
//  resetN      in   1        asynchronous active-low reset
//  probe       in   PROBE_W  signals under observation
//  arm         in   1        1-cycle pulse: start new capture (any state)
//  abort       in   1        1-cycle pulse: return to IDLE, buffer contents invalid
//  trigMask    in   PROBE_W  1 = bit participates in trigger
//  trigValue   in   PROBE_W  required level for masked bits
//  preTrig     in   ADDR_W   samples kept before trigger; latched on arm
//  capState    out  3        IDLE=0 PRE=1 WAIT=2 POST=3 DONE=4
//  triggered   out  1        high from trigger sample until next arm/abort
//  done        out  1        high in DONE
//  rdEn        in   1        read request, honoured only in DONE
//  rdAddr      in   ADDR_W   logical index, 0 = oldest sample in window
//  rdData      out  PROBE_W  sample at rdAddr
//  rdValid     out  1        pulses 1 cycle after an honoured rdEn
// BEHAVIOUR
//  - Reset: capState=IDLE, triggered=0, done=0, rdData=0, rdValid=0, pointers/counters 0.
//  - probe registered once (probe_q); compare and RAM write use probe_q -> 1-cycle input latency.
//  - Trigger hit = ((probe_q ^ trigValue) & trigMask) == 0; trigMask==0 triggers on first eligible sample.
//  - arm: latch preTrig (preTrig==0 -> skip PRE straight to WAIT), clear wrPtr/counters, triggered=0, done=0.
//  - PRE: write every cycle; trigger ignored; after preTrig writes -> WAIT.
//  - WAIT: write every cycle (ring overwrites oldest); on hit: record trigPtr=wrPtr, triggered=1 -> POST.
//  - POST: trigger sample counts as first post sample; after DEPTH-preTrig total post samples -> DONE.
//  - Window: exactly DEPTH samples; trigger sample at logical index preTrig.
//  - DONE: writes stop; physical addr = (trigPtr - preTrig + rdAddr) mod DEPTH (ADDR_W wrap).
//  - Read: rdData/rdValid registered, latency 1; rdEn outside DONE ignored, rdValid stays 0, rdData holds.
//  - arm and abort same cycle: abort wins. arm mid-capture restarts cleanly; abort -> IDLE, done=0.
//  - Async reset mid-capture: immediate return to reset values; RAM contents undefined, not cleared.
// CONFIGURATION
//  SIGCAP_EDGE_TRIG_EN defined: adds input trigEdge[PROBE_W]; masked bits with trigEdge=1 hit only when
//   probe_q bit equals trigValue AND differs from previous sample (edge into value); first sample after arm never edge-hits.
//  Undefined: port absent, level-only trigger as above.
// STRUCTURE
//  probe_capture_pkg: cap_state_e enum (IDLE..DONE), state width localparam, state encoding constants.
//  Sub-module probe_capture_ram: simple dual-port RAM, DEPTH x PROBE_W, sync write, registered read (infers BSRAM).
//  Control FSM, pointers, trigger compare and read address translation stay in probe_capture_core.
// TESTING
//  1 PROBE_W=16,DEPTH=16,preTrig=4,mask=FFFF,value=0x0005, probe=counter 0,1,2..: arm -> trigger at 5; rdAddr 0..15 reads 1..16; rdAddr4=0x0005.
//  2 preTrig=0, trigMask=0: arm -> triggered next eligible sample, done after 16 samples, rdAddr0 = first sample after arm.
//  3 Trigger value present during PRE only: not accepted; capture waits in WAIT for next occurrence; ring wrap correct at rdAddr 15->0.
//  4 abort in POST -> capState=IDLE, done=0; rdEn then yields no rdValid; arm+abort same cycle -> IDLE.
//  5 resetN low mid-POST -> all outputs at reset values same cycle; re-arm completes normal capture.
//  6 SIGCAP_EDGE_TRIG_EN, trigEdge=1 on bit0, probe bit0 held 1 across arm: no hit; 0->1 transition -> hit at that sample.

Source files
------------

// File: rtl/probe_capture_pkg.sv
// Shared state encoding for the debug-probe capture block.
package probe_capture_pkg;

    localparam int CAP_STATE_W = 3;

    typedef enum logic [CAP_STATE_W-1:0] {
        CAP_IDLE = 3'd0,
        CAP_PRE  = 3'd1,
        CAP_WAIT = 3'd2,
        CAP_POST = 3'd3,
        CAP_DONE = 3'd4
    } cap_state_e;

    // Plain vector constants so the state register stays a simple logic vector.
    localparam logic [CAP_STATE_W-1:0] ST_IDLE = CAP_IDLE;
    localparam logic [CAP_STATE_W-1:0] ST_PRE  = CAP_PRE;
    localparam logic [CAP_STATE_W-1:0] ST_WAIT = CAP_WAIT;
    localparam logic [CAP_STATE_W-1:0] ST_POST = CAP_POST;
    localparam logic [CAP_STATE_W-1:0] ST_DONE = CAP_DONE;

endpackage

// File: rtl/probe_capture_if.sv
// Probe, trigger-control and readout signals of the capture block.
// SIGCAP_EDGE_TRIG_EN adds the per-bit edge qualifier trigEdge.
interface probe_capture_if #(
    parameter int PROBE_W = 16,
    parameter int ADDR_W  = 8
);
    logic [PROBE_W-1:0] probe;
    logic               arm;
    logic               abort;
    logic [PROBE_W-1:0] trigMask;
    logic [PROBE_W-1:0] trigValue;
    logic [ADDR_W-1:0]  preTrig;
    logic [2:0]         capState;
    logic               triggered;
    logic               done;
    logic               rdEn;
    logic [ADDR_W-1:0]  rdAddr;
    logic [PROBE_W-1:0] rdData;
    logic               rdValid;
`ifdef SIGCAP_EDGE_TRIG_EN
    logic [PROBE_W-1:0] trigEdge;
`endif

    modport master (
        output probe, arm, abort, trigMask, trigValue, preTrig, rdEn, rdAddr,
        input  capState, triggered, done, rdData, rdValid
`ifdef SIGCAP_EDGE_TRIG_EN
        , output trigEdge
`endif
    );

    modport slave (
        input  probe, arm, abort, trigMask, trigValue, preTrig, rdEn, rdAddr,
        output capState, triggered, done, rdData, rdValid
`ifdef SIGCAP_EDGE_TRIG_EN
        , input trigEdge
`endif
    );

endinterface

// File: rtl/probe_capture_ram.sv
// Simple dual-port sample store: synchronous write, registered read that holds when idle.
module probe_capture_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the output register is reset; the array keeps whatever it held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/probe_capture_core.sv
// Debug-probe capture engine: mask/value trigger, pre-trigger ring buffer, translated readout.
// Define SIGCAP_EDGE_TRIG_EN to qualify selected trigger bits with a transition into the value.
//
// state | meaning
// IDLE  | no capture running, buffer contents not valid
// PRE   | filling pre-trigger history, trigger ignored
// WAIT  | ring keeps rolling, watching for a trigger hit
// POST  | trigger seen, collecting the rest of the window
// DONE  | window frozen, host may read
module probe_capture_core
    import probe_capture_pkg::*;
#(
    parameter int PROBE_W = 16,
    parameter int DEPTH   = 256
) (
    input logic            controlCLK,
    input logic            resetN,
    probe_capture_if.slave cap
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    logic [PROBE_W-1:0]     probe_q;
    logic [CAP_STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]      pre_q, pre_d;
    logic [ADDR_W-1:0]      trig_ptr_q, trig_ptr_d;
    logic                   triggered_q, triggered_d;
    logic                   rd_valid_q;
    logic                   wr_en, hit, rd_take;
    logic [ADDR_W-1:0]      rd_phys;
    logic [PROBE_W-1:0]     lvl_miss, rd_data;

    assign lvl_miss = (probe_q ^ cap.trigValue) & cap.trigMask;

`ifdef SIGCAP_EDGE_TRIG_EN
    logic [PROBE_W-1:0] prev_q, edge_bits;
    logic               first_q;

    assign edge_bits = cap.trigMask & cap.trigEdge;
    // Edge bits must also have toggled since the previous sample; sample 0 has no history.
    assign hit = (lvl_miss == '0) &&
                 ((edge_bits == '0) ||
                  (!first_q && (((probe_q ^ prev_q) & edge_bits) == edge_bits)));

    always_ff @(posedge controlCLK or negedge resetN) begin
        if (!resetN) begin
            prev_q  <= '0;
            first_q <= 1'b0;
        end else begin
            prev_q <= probe_q;
            if (cap.arm) begin
                first_q <= 1'b1;
            end else if (wr_en) begin
                first_q <= 1'b0;
            end
        end
    end
`else
    assign hit = (lvl_miss == '0);
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        trig_ptr_d  = trig_ptr_q;
        triggered_d = triggered_q;
        wr_en       = 1'b0;
        if (cap.abort) begin
            state_d     = ST_IDLE;
            triggered_d = 1'b0;
        end else if (cap.arm) begin
            pre_d       = cap.preTrig;
            cnt_d       = cap.preTrig;
            wr_ptr_d    = '0;
            trig_ptr_d  = '0;
            triggered_d = 1'b0;
            state_d     = (cap.preTrig == '0) ? ST_WAIT : ST_PRE;
        end else begin
            case (state_q)
                ST_PRE: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE;
                    cnt_d    = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE;
                    if (hit) begin
                        // Trigger sample is the first post sample; cnt holds the ones still owed.
                        trig_ptr_d  = wr_ptr_q;
                        triggered_d = 1'b1;
                        cnt_d       = LAST_IDX - pre_q;
                        state_d     = (LAST_IDX == pre_q) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE;
                    cnt_d    = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge controlCLK or negedge resetN) begin
        if (!resetN) begin
            probe_q     <= '0;
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            pre_q       <= '0;
            trig_ptr_q  <= '0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            probe_q     <= cap.probe;
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            trig_ptr_q  <= trig_ptr_d;
            triggered_q <= triggered_d;
            rd_valid_q  <= rd_take;
        end
    end

    assign rd_take = cap.rdEn && (state_q == ST_DONE);
    assign rd_phys = trig_ptr_q - pre_q + cap.rdAddr;

    probe_capture_ram #(
        .WIDTH (PROBE_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (controlCLK),
        .rst_n     (resetN),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (probe_q),
        .rd_en_i   (rd_take),
        .rd_addr_i (rd_phys),
        .rd_data_o (rd_data)
    );

    assign cap.capState  = state_q;
    assign cap.triggered = triggered_q;
    assign cap.done      = (state_q == ST_DONE);
    assign cap.rdData    = rd_data;
    assign cap.rdValid   = rd_valid_q;

endmodule

// File: tb/tb_probe_capture_core.sv
// Randomized scoreboard bench for probe_capture_core (PROBE_W=16, DEPTH=16).
module tb_probe_capture_core;
    import probe_capture_pkg::*;

    localparam int PROBE_W = 16;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int STIM_N  = 128;

    logic clk = 1'b0;
    logic resetN;

    probe_capture_if #(.PROBE_W(PROBE_W), .ADDR_W(ADDR_W)) cap_if ();

    probe_capture_core #(.PROBE_W(PROBE_W), .DEPTH(DEPTH)) dut (
        .controlCLK (clk),
        .resetN     (resetN),
        .cap        (cap_if)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [15:0] stim [STIM_N];
    logic [15:0] win  [DEPTH];
    logic [15:0] exp_q [$];
    logic [15:0] exp_d;
    logic [15:0] last_rd = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every rdValid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (cap_if.rdValid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected: rdValid=1 with no read outstanding, rdData=%h", cap_if.rdData);
            end else begin
                exp_d   = exp_q.pop_front();
                last_rd = exp_d;
                if (cap_if.rdData !== exp_d) begin
                    miscompares++;
                    $display("FAIL rd_data: got %h expected %h", cap_if.rdData, exp_d);
                end
            end
        end
    end

    // Reference: first sample at or after pre that satisfies the trigger rule.
    function automatic int find_trig(input int pre, input logic [15:0] mask,
                                     input logic [15:0] val, input logic [15:0] edg);
        logic [15:0] s;
        for (int k = pre; k < STIM_N; k++) begin
            s = stim[k];
            if (((s ^ val) & mask) != 16'h0) continue;
            if ((mask & edg) != 16'h0) begin
                if (k == 0) continue;
                if (((s ^ stim[k-1]) & mask & edg) != (mask & edg)) continue;
            end
            return k;
        end
        return -1;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < STIM_N; i++) stim[i] = 16'($urandom);
    endtask

    // Drives one capture from arm; stop_at>=0 ends early (with abort if do_abort).
    task automatic run_capture(input int pre, input logic [15:0] mask, input logic [15:0] val,
                               input logic [15:0] edg, input int stop_at, input bit do_abort);
        int t, last, c;
        logic [2:0] es;
        t = find_trig(pre, mask, val, edg);
        if (t < 0 || t + DEPTH - pre + 1 >= STIM_N) begin
            vectors++;
            miscompares++;
            $display("FAIL model: no usable trigger in stimulus (t=%0d)", t);
            return;
        end
        last = t + DEPTH - pre - 1;
        for (int i = 0; i < DEPTH; i++) win[i] = stim[t - pre + i];
        cap_if.preTrig   = ADDR_W'(pre);
        cap_if.trigMask  = mask;
        cap_if.trigValue = val;
`ifdef SIGCAP_EDGE_TRIG_EN
        cap_if.trigEdge  = edg;
`endif
        c = 0;
        while (1) begin
            cap_if.probe = stim[c];
            cap_if.arm   = (c == 0);
            cap_if.abort = do_abort && (c == stop_at);
            @(negedge clk);
            cap_if.arm   = 1'b0;
            cap_if.abort = 1'b0;
            if (do_abort && c == stop_at) begin
                check("abort_state", 32'(cap_if.capState), 32'(CAP_IDLE));
                check("abort_done", 32'(cap_if.done), 32'd0);
                check("abort_trig", 32'(cap_if.triggered), 32'd0);
                return;
            end
            if (c < pre)        es = CAP_PRE;
            else if (c <= t)    es = CAP_WAIT;
            else if (c <= last) es = CAP_POST;
            else                es = CAP_DONE;
            check("capState", 32'(cap_if.capState), 32'(es));
            check("triggered", 32'(cap_if.triggered), 32'(c > t));
            check("done", 32'(cap_if.done), 32'(c > last));
            if (c == stop_at || c > last) break;
            c++;
        end
    endtask

    task automatic read_window(input int n_rand);
        int a;
        for (int i = 0; i < DEPTH + n_rand; i++) begin
            a = (i < DEPTH) ? i : int'($urandom_range(0, DEPTH - 1));
            cap_if.rdEn   = 1'b1;
            cap_if.rdAddr = ADDR_W'(a);
            exp_q.push_back(win[a]);
            @(negedge clk);
        end
        cap_if.rdEn = 1'b0;
        #1;
        check("read_latency_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] mask, val, edg;
        int pre, p;
        resetN = 1'b0;
        cap_if.probe = '0; cap_if.arm = 1'b0; cap_if.abort = 1'b0;
        cap_if.trigMask = '0; cap_if.trigValue = '0; cap_if.preTrig = '0;
        cap_if.rdEn = 1'b0; cap_if.rdAddr = '0;
`ifdef SIGCAP_EDGE_TRIG_EN
        cap_if.trigEdge = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_state", 32'(cap_if.capState), 32'(CAP_IDLE));
        check("rst_trig", 32'(cap_if.triggered), 32'd0);
        check("rst_done", 32'(cap_if.done), 32'd0);
        check("rst_rdData", 32'(cap_if.rdData), 32'd0);
        check("rst_rdValid", 32'(cap_if.rdValid), 32'd0);
        resetN = 1'b1;
        @(negedge clk);

        // Counter probe, trigger on 5 with four samples of history.
        for (int i = 0; i < STIM_N; i++) stim[i] = 16'(i + 1);
        run_capture(4, 16'hFFFF, 16'h0005, 16'h0, -1, 1'b0);
        read_window(4);

        // No history, mask 0: first sample after arm triggers.
        fill_random();
        run_capture(0, 16'h0000, 16'($urandom), 16'h0, -1, 1'b0);
        read_window(4);

        // Trigger value inside PRE is ignored; real hit later, window wraps the ring.
        fill_random();
        for (int i = 0; i < STIM_N; i++) if (stim[i] == 16'hAAAA) stim[i] = 16'h5555;
        stim[2]  = 16'hAAAA;
        stim[30] = 16'hAAAA;
        run_capture(4, 16'hFFFF, 16'hAAAA, 16'h0, -1, 1'b0);
        read_window(0);

        // Abort in POST, then a read outside DONE must be ignored.
        fill_random();
        run_capture(2, 16'h0000, 16'h0, 16'h0, 4, 1'b1);
        cap_if.rdEn = 1'b1; cap_if.rdAddr = 4'd3;
        @(negedge clk);
        cap_if.rdEn = 1'b0;
        #1;
        check("idle_rdValid", 32'(cap_if.rdValid), 32'd0);
        check("idle_rdData_hold", 32'(cap_if.rdData), 32'(last_rd));

        // arm and abort together from DONE: abort wins.
        fill_random();
        run_capture(0, 16'h0000, 16'h0, 16'h0, -1, 1'b0);
        cap_if.arm = 1'b1; cap_if.abort = 1'b1;
        @(negedge clk);
        cap_if.arm = 1'b0; cap_if.abort = 1'b0;
        check("arm_abort_state", 32'(cap_if.capState), 32'(CAP_IDLE));
        check("arm_abort_done", 32'(cap_if.done), 32'd0);

        // Asynchronous reset in POST, then a clean re-arm.
        fill_random();
        run_capture(3, 16'h0000, 16'h0, 16'h0, 5, 1'b0);
        #2;
        resetN = 1'b0;
        #1;
        check("mid_rst_state", 32'(cap_if.capState), 32'(CAP_IDLE));
        check("mid_rst_trig", 32'(cap_if.triggered), 32'd0);
        check("mid_rst_done", 32'(cap_if.done), 32'd0);
        check("mid_rst_rdData", 32'(cap_if.rdData), 32'd0);
        check("mid_rst_rdValid", 32'(cap_if.rdValid), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        fill_random();
        run_capture(5, 16'h0000, 16'h0, 16'h0, -1, 1'b0);
        read_window(2);

`ifdef SIGCAP_EDGE_TRIG_EN
        // bit0 held high across arm must not hit; the later 0->1 transition must.
        cap_if.probe = 16'h0001;
        repeat (2) @(negedge clk);
        fill_random();
        for (int i = 0; i < 6; i++) stim[i] = stim[i] | 16'h0001;
        stim[6] = stim[6] & 16'hFFFE;
        stim[7] = stim[7] | 16'h0001;
        run_capture(0, 16'h0001, 16'h0001, 16'h0001, -1, 1'b0);
        read_window(2);
`endif

        // Randomized captures with sparse masks and a planted hit.
        for (int n = 0; n < 8; n++) begin
            fill_random();
            pre  = int'($urandom_range(0, DEPTH - 1));
            mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
            val  = 16'($urandom);
            edg  = 16'h0;
`ifdef SIGCAP_EDGE_TRIG_EN
            edg  = mask & 16'($urandom);
`endif
            p = pre + 1 + int'($urandom_range(0, 40));
            stim[p] = (stim[p] & ~mask) | (val & mask);
            stim[p-1] = (stim[p-1] & ~edg) | (~val & edg);
            run_capture(pre, mask, val, edg, -1, 1'b0);
            read_window(6);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
